// File: rtl/mnist_layer_sequencer.sv
// rtl/mnist_layer_sequencer.sv - Avalon-MM layer sequencer driving the MNIST accelerator core
// Optional SEQ_WATCHDOG_EN: WAIT-state watchdog that returns to IDLE and flags timeout.
module mnist_layer_sequencer #(
  parameter int          MAX_LAYERS    = 4,
  parameter logic [15:0] WEIGHT_STRIDE = 16'h0400,
  parameter logic [23:0] WDT_CYCLES    = 24'd5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  input  logic [7:0]  pixel_data,
  input  logic [31:0] acc_image_idx,
  output logic [15:0] mem_idx,
  output logic        acc_go,
  output logic [2:0]  acc_layer_index,
  output logic [15:0] acc_data_address,
  output logic [15:0] acc_weight_address,
  input  logic [2:0]  acc_done,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LOAD, GO, WAIT, GAP, FINISH} state_t;
  localparam logic [2:0] MAX_L = 3'(MAX_LAYERS);

  state_t      state;
  logic [15:0] sw_ptr, data_addr, weight_addr, weight_base, layer_offset;
  logic [2:0]  num_layers, num_snap, layer, last_done_code;
  logic        done, aborted, timeout;
  logic        wr, rd, start, abort, count_ok;
  logic        unused_bits;

  assign wr           = chipselect & write;
  assign rd           = chipselect & read;
  assign start        = wr && (address == 3'd2) && writedata[0];
  assign abort        = wr && (address == 3'd2) && writedata[1];
  assign count_ok     = (num_layers != 3'd0) && (num_layers <= MAX_L);
  assign layer_offset = 16'(layer) * WEIGHT_STRIDE;
  assign mem_idx      = busy ? acc_image_idx[15:0] : sw_ptr;
  assign unused_bits  = ^{acc_image_idx[31:16], WDT_CYCLES};

`ifdef SEQ_WATCHDOG_EN
  logic [23:0] wdt_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      sw_ptr             <= 16'h0;
      data_addr          <= 16'h0;
      weight_addr        <= 16'h0;
      weight_base        <= 16'h0;
      num_layers         <= 3'd0;
      num_snap           <= 3'd0;
      layer              <= 3'd0;
      last_done_code     <= 3'd0;
      done               <= 1'b0;
      aborted            <= 1'b0;
      timeout            <= 1'b0;
      readdata           <= 8'h0;
      acc_go             <= 1'b0;
      acc_layer_index    <= 3'd0;
      acc_data_address   <= 16'h0;
      acc_weight_address <= 16'h0;
      busy               <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wdt_cnt            <= 24'd0;
`endif
    end else begin
      acc_go <= 1'b0;

      // Pixel pointer is always writable; configuration is frozen while a sequence runs.
      if (wr) begin
        case (address)
          3'd0: sw_ptr[7:0]  <= writedata;
          3'd1: sw_ptr[15:8] <= writedata;
          3'd3: if (!busy) num_layers        <= writedata[2:0];
          3'd4: if (!busy) data_addr[7:0]    <= writedata;
          3'd5: if (!busy) data_addr[15:8]   <= writedata;
          3'd6: if (!busy) weight_addr[7:0]  <= writedata;
          3'd7: if (!busy) weight_addr[15:8] <= writedata;
          default: ;
        endcase
      end

      if (rd) begin
        case (address)
          3'd0:    readdata <= {1'b0, layer, timeout, aborted, done, busy};
          3'd1:    readdata <= pixel_data;
          3'd2:    readdata <= {5'b0, layer};
          3'd3:    readdata <= {5'b0, last_done_code};
          3'd4:    readdata <= data_addr[7:0];
          3'd5:    readdata <= data_addr[15:8];
          3'd6:    readdata <= weight_addr[7:0];
          default: readdata <= weight_addr[15:8];
        endcase
      end

      if (abort && state != IDLE) begin
        state   <= IDLE;
        busy    <= 1'b0;
        aborted <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              if (count_ok) begin
                state            <= LOAD;
                busy             <= 1'b1;
                layer            <= 3'd0;
                done             <= 1'b0;
                aborted          <= 1'b0;
                timeout          <= 1'b0;
                num_snap         <= num_layers;
                acc_data_address <= data_addr;
                weight_base      <= weight_addr;
              end else begin
                aborted <= 1'b1;
              end
            end
          end
          LOAD: begin
            acc_layer_index    <= layer;
            acc_weight_address <= weight_base + layer_offset;
            state              <= GO;
          end
          GO: begin
            acc_go <= 1'b1;
            state  <= WAIT;
`ifdef SEQ_WATCHDOG_EN
            wdt_cnt <= 24'd0;
`endif
          end
          WAIT: begin
            if (acc_done != 3'd0) begin
              last_done_code <= acc_done;
              state          <= (layer == num_snap - 3'd1) ? FINISH : GAP;
            end
`ifdef SEQ_WATCHDOG_EN
            else if (wdt_cnt == WDT_CYCLES - 24'd1) begin
              state   <= IDLE;
              busy    <= 1'b0;
              timeout <= 1'b1;
            end else begin
              wdt_cnt <= wdt_cnt + 24'd1;
            end
`endif
          end
          GAP: begin
            // Never re-arm the core until it has released its done code.
            if (acc_done == 3'd0) begin
              layer <= layer + 3'd1;
              state <= LOAD;
            end
          end
          FINISH: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mnist_layer_sequencer.md
Name: mnist_layer_sequencer

Overview:
- Avalon-MM 8-bit slave plus FSM that sequences the MNIST accelerator core through N layers using a go/done handshake.
- Shadows the data and weight base addresses and computes the per-layer weight address.
- Arbitrates the camera-frame pixel read index between software (HPS readback) and the accelerator's image_idx.
- Sits between the HPS bridge and the camera_interface/top pair inside the peripheral.

Parameters:
- MAX_LAYERS, 4, largest accepted layer count (1..7).
- WEIGHT_STRIDE, 16'h0400, weight-address increment per layer.
- WDT_CYCLES, 24'd5000000, watchdog limit in clk cycles (used only with SEQ_WATCHDOG_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- chipselect  in  1  Avalon select
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- address  in  3  register index
- writedata  in  8  write data
- readdata  out  8  registered read data
- pixel_data  in  8  pixel byte from frame buffer, returned on reads
- acc_image_idx  in  32  accelerator pixel index request
- mem_idx  out  16  frame-buffer read index (arbitrated)
- acc_go  out  1  one-cycle start pulse to the accelerator
- acc_layer_index  out  3  current layer
- acc_data_address  out  16  data base address
- acc_weight_address  out  16  weight address for the current layer
- acc_done  in  3  accelerator done code; nonzero means the layer is complete
- busy  out  1  sequence in progress

Behaviour:
Register map; reads return on readdata 1 cycle after the chipselect&read edge.
- Addr 0: W PIX_LOW (sw_ptr[7:0]); R STATUS = {1'b0, layer[2:0], timeout, aborted, done, busy}.
- Addr 1: W PIX_UP (sw_ptr[15:8]); R pixel_data.
- Addr 2: W CTRL; bit0 = start, bit1 = abort; bits are self-clearing. R {5'b0, layer}.
- Addr 3: W NUM_LAYERS[2:0]; R {5'b0, last_done_code}.
- Addr 4/5: DATA_ADDR lo/hi.
- Addr 6/7: WEIGHT_ADDR lo/hi.
- Addr 4..7 read back their stored values.
- Writes to addr 3..7 while busy are ignored. PIX_LOW/PIX_UP are always accepted.

Arbitration:
- mem_idx = busy ? acc_image_idx[15:0] : sw_ptr.
- Combinational; switches in the cycle busy changes.

FSM states: IDLE, LOAD, GO, WAIT, GAP, FINISH.
- IDLE: start with 1 <= num_layers <= MAX_LAYERS -> LOAD. Actions: layer = 0; clear done, aborted, timeout; snapshot DATA_ADDR, WEIGHT_ADDR and num_layers. Start with an illegal count is ignored and sets aborted = 1.
- LOAD: drive acc_layer_index = layer, acc_weight_address = weight_base + layer*WEIGHT_STRIDE (16-bit, wraps mod 2^16); -> GO.
- GO: acc_go = 1 for exactly one cycle; -> WAIT.
- WAIT: on acc_done != 0, capture last_done_code = acc_done. If layer == num_layers-1 -> FINISH, else -> GAP.
- GAP: hold until acc_done == 0, then layer++ and -> LOAD. The next go is never issued while done is still high.
- FINISH: done = 1 (sticky until the next start); -> IDLE.
- busy = 1 in every state except IDLE.
- Start while busy is ignored.
- Abort in any non-IDLE state: -> IDLE next cycle, aborted = 1, no further acc_go; the layer field holds its last value. Abort while in IDLE has no effect.
- Start and abort written in the same cycle: abort wins; the sequence does not start.

Reset (synchronous):
- readdata = 0, acc_go = 0, acc_layer_index = 0, acc_data_address = 0, acc_weight_address = 0, busy = 0.
- All registers = 0; state = IDLE.
- Reset mid-sequence aborts immediately with no go pulse; aborted remains 0.

Latency:
- Start write edge to acc_go high: 3 cycles (IDLE->LOAD->GO).
- acc_done rising to the next acc_go, when done drops the following cycle: 4 cycles.

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- Defined: a 24-bit counter clears on entry to WAIT and increments each WAIT cycle. Reaching WDT_CYCLES with acc_done still 0 -> IDLE, timeout = 1, busy = 0.
- Not defined: no counter; WAIT waits indefinitely; STATUS bit3 always reads 0.

Test Plan:
- Reset, then read addr 0 -> 8'h00. Write PIX 0x1234, read addr 1 -> mem_idx == 16'h1234 and readdata equals pixel_data one cycle later.
- NUM_LAYERS = 3, WEIGHT = 0x0100, start; model pulses done after 10 cycles -> exactly 3 acc_go pulses, weight addresses 0x0100/0x0500/0x0900, layers 0/1/2; STATUS then reads 8'h22 (layer 2, done).
- While busy, write WEIGHT_ADDR lo = 0xFF and start -> no effect; addr 6 still reads 0x00; no extra go.
- Hold acc_done high for 5 cycles after layer 0 -> next acc_go occurs 3 cycles after done falls, never while done is high.
- Abort during WAIT of layer 1 -> busy = 0 next cycle, STATUS = 8'h14, mem_idx returns to sw_ptr, no further go; start with NUM_LAYERS = 0 -> aborted = 1, busy stays 0.
- With SEQ_WATCHDOG_EN and WDT_CYCLES = 100, done never asserted -> busy drops after 100 WAIT cycles, STATUS bit3 = 1.
